// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory sequencer.
package mem_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    // Access size class derived from funct3
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    // funct3 size codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Writeback select codes, shared with the writeback stage
    localparam logic [2:0] WBS_NONE = 3'd0;
    localparam logic [2:0] WBS_LB   = 3'd1;
    localparam logic [2:0] WBS_LH   = 3'd2;
    localparam logic [2:0] WBS_LBU  = 3'd3;
    localparam logic [2:0] WBS_LHU  = 3'd4;
    localparam logic [2:0] WBS_LW   = 3'd5;

    // Invalid codes fall into the word class
    function automatic mem_size_e size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_of = SZ_B;
            F3_H, F3_HU: size_of = SZ_H;
            default:     size_of = SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (size_of(f3))
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [2:0] wbs_code(input logic [2:0] f3);
        case (f3)
            F3_B:    wbs_code = WBS_LB;
            F3_H:    wbs_code = WBS_LH;
            F3_BU:   wbs_code = WBS_LBU;
            F3_HU:   wbs_code = WBS_LHU;
            F3_W:    wbs_code = WBS_LW;
            default: wbs_code = WBS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and lane replication, load right-shift.
module mem_lane_align
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WordSize = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            wr_off,
    input  logic [WordSize-1:0]   wdata,
    input  logic [1:0]            rd_off,
    input  logic [WordSize-1:0]   rdata,
    output logic [WordSize/8-1:0] be_c,
    output logic [WordSize-1:0]   wdata_rep_c,
    output logic [WordSize-1:0]   rdata_sh_c
);

    localparam int unsigned BeW = WordSize / 8;

    // Store lane selection and replication by access size
    always_comb begin
        be_c        = '1;
        wdata_rep_c = wdata;
        case (size_of(funct3))
            SZ_B: begin
                be_c        = BeW'(1) << wr_off;
                wdata_rep_c = {(WordSize / 8){wdata[7:0]}};
            end
            SZ_H: begin
                be_c        = BeW'(2'b11) << {wr_off[1], 1'b0};
                wdata_rep_c = {(WordSize / 16){wdata[15:0]}};
            end
            default: begin
                be_c        = '1;
                wdata_rep_c = wdata;
            end
        endcase
    end

    // Loaded word shifted so the addressed byte lands in bits [7:0]
    always_comb begin
        rdata_sh_c = rdata >> {rd_off, 3'b000};
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory port sequencer: issues one bus access per load/store,
// stalls the pipeline while it is in flight, aligns read data and produces the
// writeback select. Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WordSize = 32,
`ifdef MEM_TIMEOUT_EN
    parameter int unsigned TimeoutCycles = 255,
`endif
    parameter int unsigned AddrSize = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mem_en,
    input  logic                  mem_we,
    input  logic [2:0]            funct3,
    input  logic [AddrSize-1:0]   addr,
    input  logic [WordSize-1:0]   wdata,
    output logic                  stall,
    output logic [2:0]            wbs_out,
    output logic [WordSize-1:0]   mrd_out,
    output logic                  fault,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [AddrSize-1:0]   bus_addr,
    output logic [WordSize/8-1:0] bus_be,
    output logic [WordSize-1:0]   bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [WordSize-1:0]   bus_rdata
);

    localparam int unsigned BeW = WordSize / 8;

    mem_state_e          state_q, state_nx;
    logic                misalign_c;
    logic                accept_c;
    logic                misalign_flt_c;
    logic                tmo_flt_c;
    logic                rd_cap_c;
    logic                timeout_c;
    logic                busy_c;
    logic [2:0]          funct3_q;
    logic [1:0]          off_q;
    logic [BeW-1:0]      be_c;
    logic [WordSize-1:0] wdata_rep_c;
    logic [WordSize-1:0] rdata_sh_c;

    mem_lane_align #(
        .WordSize (WordSize)
    ) u_align (
        .funct3      (funct3),
        .wr_off      (addr[1:0]),
        .wdata       (wdata),
        .rd_off      (off_q),
        .rdata       (bus_rdata),
        .be_c        (be_c),
        .wdata_rep_c (wdata_rep_c),
        .rdata_sh_c  (rdata_sh_c)
    );

    assign busy_c = (state_q == REQ) || (state_q == WAIT);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;

    logic [CntW-1:0] tmo_cnt_q;

    // Cycles spent in REQ/WAIT for the current access
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_q <= '0;
        end else if (busy_c && ((state_nx == REQ) || (state_nx == WAIT))) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign timeout_c = busy_c && (tmo_cnt_q == CntW'(TimeoutCycles - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Pipeline freeze while an accepted access is outstanding
    assign stall = ((state_q == IDLE) && mem_en && !misalign_c) || busy_c;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state and per-cycle event decode
    always_comb begin
        state_nx       = state_q;
        accept_c       = 1'b0;
        misalign_flt_c = 1'b0;
        tmo_flt_c      = 1'b0;
        rd_cap_c       = 1'b0;
        misalign_c     = is_misaligned(funct3, addr[1:0]);
        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    if (misalign_c) begin
                        misalign_flt_c = 1'b1;
                    end else begin
                        accept_c = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_nx = bus_we ? DONE : WAIT;
                end else if (timeout_c) begin
                    tmo_flt_c = 1'b1;
                    state_nx  = DONE;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    rd_cap_c = 1'b1;
                    state_nx = DONE;
                end else if (timeout_c) begin
                    tmo_flt_c = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Bus request/payload, read data, writeback select and fault registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            funct3_q  <= 3'b000;
            off_q     <= 2'b00;
            mrd_out   <= '0;
            wbs_out   <= WBS_NONE;
            fault     <= 1'b0;
        end else begin
            bus_req <= (state_nx == REQ);
            fault   <= misalign_flt_c || tmo_flt_c;
            if (accept_c) begin
                bus_we    <= mem_we;
                bus_addr  <= {addr[AddrSize-1:2], 2'b00};
                bus_be    <= mem_we ? be_c : '1;
                bus_wdata <= wdata_rep_c;
                funct3_q  <= funct3;
                off_q     <= addr[1:0];
            end
            if (rd_cap_c) begin
                mrd_out <= rdata_sh_c;
            end else if (tmo_flt_c) begin
                mrd_out <= '0;
            end
            if (misalign_flt_c || tmo_flt_c) begin
                wbs_out <= WBS_NONE;
            end else if ((state_nx == DONE) && (state_q != DONE)) begin
                wbs_out <= bus_we ? WBS_NONE : wbs_code(funct3_q);
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage's single data-memory port. It accepts one load or store per instruction from the EX/MEM boundary and stalls the pipeline while the bus handshake is in flight. It produces byte-lane-aligned read data plus the 3-bit writeback select consumed by the MEM/WB register, and flags misaligned or timed-out accesses.

## Interface
- WordSize, 32, data width; only 32 is supported; byte-enable width is WordSize/8.
- AddrSize, 32, address width.
- TimeoutCycles, 255, bus wait limit in cycles; used only with MEM_TIMEOUT_EN.
- Clock and reset: clk is the clock; rstn is the reset, asynchronous, active-low.
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- mem_en  in  1  MEM-stage instruction is a load or store
- mem_we  in  1  1 = store, 0 = load
- funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  AddrSize  byte address
- wdata  in  WordSize  store data, right-aligned
- stall  out  1  freeze IF..MEM stages
- wbs_out  out  3  writeback select: 0 ALU/none, 1 LB, 2 LH, 3 LBU, 4 LHU, 5 LW
- mrd_out  out  WordSize  loaded word shifted right by 8*addr[1:0]
- fault  out  1  one-cycle pulse: misaligned access or timeout
- bus_req, bus_we  out  1  request strobe and direction
- bus_addr  out  AddrSize  word-aligned address, {addr[AddrSize-1:2],2'b00}
- bus_be  out  WordSize/8  byte enables; all ones for loads
- bus_wdata  out  WordSize  lane-replicated store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  read data valid
- bus_rdata  in  WordSize  read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, mem_en=1, aligned: latch addr, funct3, mem_we and wdata; go to REQ.
- IDLE, mem_en=1, misaligned (H/HU/SH with addr[0]=1; W with addr[1:0]≠0): no bus access, fault=1, wbs_out=0, stay in IDLE.
- REQ: bus_req=1 until bus_gnt is sampled high. Store goes to DONE; load goes to WAIT.
- WAIT: on bus_rvalid, capture the shifted bus_rdata into mrd_out and go to DONE. bus_rvalid is ignored in every other state.
- DONE: stall=0 so the pipeline advances; mem_en is ignored; go to IDLE next cycle.
- stall = (IDLE & mem_en & aligned) | REQ | WAIT.
- wbs_out is registered on entry to DONE: 0 for stores, otherwise the code for funct3. It is held until the next DONE or fault.
- Byte enables:
  - SB: bus_be = 1<<addr[1:0]; byte replicated to all 4 lanes.
  - SH: bus_be = addr[1] ? 1100 : 0011; halfword replicated.
  - SW: bus_be = 1111.
- Invalid funct3 (011, 110, 111) is treated as W-size for alignment and bus_be; wbs_out=0.

## Timing
- Reset values: state IDLE. bus_req, bus_we, bus_addr, bus_be, bus_wdata, mrd_out, wbs_out and fault are all 0. stall follows mem_en through IDLE.
- Bus outputs are registered; bus_req asserts the cycle after IDLE acceptance.
- Minimum stall with single-cycle gnt and rvalid: load 3 cycles, store 2 cycles.
- bus_req deasserts in the cycle after gnt; bus outputs are stable while bus_req=1.
- Reset mid-access: bus_req drops asynchronously, and any pending response is discarded.
- Back-to-back accesses: the earliest next acceptance is the cycle after DONE.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit-minimum counter (width from TimeoutCycles) runs in REQ and WAIT and clears on leaving them.
  - On reaching TimeoutCycles: go to DONE, set fault=1, mrd_out=0, wbs_out=0, bus_req=0.
- MEM_TIMEOUT_EN undefined: no counter; REQ and WAIT wait indefinitely; fault comes only from misalignment.

## Structure
- Package mem_ctrl_pkg holds:
  - the state enum;
  - the funct3 size constants;
  - the wbs code constants (shared with the writeback stage).
- Sub-module mem_lane_align, combinational, produces bus_be and lane-replicated wdata from size and addr[1:0], and right-shifts read data.

## Test plan
- LB at addr 0x103, rdata 0xAABBCCDD, gnt and rvalid one cycle each -> 3 stall cycles, mrd_out=0x000000AA, wbs_out=1.
- SH at addr 0x202, wdata 0x1234 -> bus_be=1100, bus_wdata=0x12341234, bus_addr=0x200, 2 stall cycles, wbs_out=0.
- LW at addr 0x102 -> fault pulse, no bus_req, stall=0, wbs_out=0.
- LHU with gnt delayed 4 cycles and rvalid delayed 2 more -> bus_req held stable for 5 cycles, stall for 8 cycles, wbs_out=4.
- rstn asserted in WAIT -> bus_req=0 and state IDLE; a later rvalid pulse does not change mrd_out.
- With MEM_TIMEOUT_EN and TimeoutCycles=10, gnt never asserted -> fault after 10 REQ cycles, stall released, wbs_out=0.
